// File: rtl/finish_req_gen_pkg.sv
// Shared constants and state encoding for the finish request producer and its
// consumer-side monitor.
package finish_req_gen_pkg;

    localparam int FINISH_ARG_W = 9;
    localparam int EXITCODE_W   = 8;
    localparam logic [EXITCODE_W-1:0] WATCHDOG_EXITCODE = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FIRE   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    // A store only arms an exit when it hits TOHOST, writes the low halfword
    // and carries the "exit" tag in bit 0.
    function automatic logic is_exit_req(input logic [31:0] addr,
                                         input logic [31:0] tohost,
                                         input logic [1:0]  be_lo,
                                         input logic        tag);
        return (addr == tohost) && (be_lo == 2'b11) && tag;
    endfunction

endpackage

// File: rtl/finish_req_gen_watchdog.sv
// IDLE-cycle watchdog: counts enabled cycles and pulses o_expire on the
// terminal count. WATCHDOG_CYCLES of 0 disables expiry entirely.
module finish_watchdog #(
    parameter int unsigned WATCHDOG_CYCLES = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);

    localparam logic [31:0] WD_TC = 32'(WATCHDOG_CYCLES) - 32'd1;

    logic [31:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en)  r_cnt <= r_cnt + 32'd1;
    end

    assign o_expire = (WATCHDOG_CYCLES != 0) && i_en && (r_cnt == WD_TC);

endmodule

// File: rtl/finish_req_gen.sv
// TOHOST MMIO slave: arms an exit on a tagged store, waits for console drain,
// emits one {finish, exitcode} strobe and then parks until reset.
module finish_req_gen
    import finish_req_gen_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR     = 32'h4000_1000,
    parameter int unsigned DRAIN_QUIET     = 16,
    parameter int unsigned WATCHDOG_CYCLES = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_st_valid,
    output logic                    o_st_ready,
    input  logic [31:0]             i_st_addr,
    input  logic [31:0]             i_st_data,
    input  logic [3:0]              i_st_byte_en,
    input  logic                    i_drain_busy,
    output logic [FINISH_ARG_W-1:0] o_finish_arg,
    output logic                    o_halted,
    output logic                    o_timed_out
);

    localparam int QW = $clog2(DRAIN_QUIET + 1);
    localparam logic [QW-1:0] QUIET_TC = QW'(DRAIN_QUIET);

    state_t                r_state;
    logic [EXITCODE_W-1:0] r_code;
    logic [QW-1:0]         r_quiet;

    logic w_exit_req;
    logic w_wd_en;
    logic w_wd_expire;
    logic w_unused;

    assign o_st_ready = (r_state == ST_IDLE) || (r_state == ST_HALTED);
    assign w_exit_req = i_st_valid && (r_state == ST_IDLE) &&
                        is_exit_req(i_st_addr, TOHOST_ADDR, i_st_byte_en[1:0], i_st_data[0]);
    assign w_wd_en    = (r_state == ST_IDLE);
    assign w_unused   = &{1'b0, i_st_data[31:9], i_st_byte_en[3:2]};

    finish_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_wd (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_wd_en),
        .i_clr   (!w_wd_en),
        .o_expire(w_wd_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_code       <= '0;
            r_quiet      <= '0;
            o_finish_arg <= '0;
            o_halted     <= 1'b0;
            o_timed_out  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A store landing on the watchdog's last cycle takes priority.
                    if (w_exit_req) begin
                        r_code  <= i_st_data[8:1];
                        r_quiet <= '0;
                        r_state <= ST_DRAIN;
                    end else if (w_wd_expire) begin
                        r_code      <= WATCHDOG_EXITCODE;
                        o_timed_out <= 1'b1;
                        r_quiet     <= '0;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_drain_busy)           r_quiet <= '0;
                    else if (r_quiet != QUIET_TC) r_quiet <= r_quiet + 1'b1;
                    if (r_quiet == QUIET_TC) begin
                        o_finish_arg <= {1'b1, r_code};
                        r_state      <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    o_finish_arg <= {1'b0, r_code};
                    o_halted     <= 1'b1;
                    r_state      <= ST_HALTED;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_finish_req_gen.sv
// Directed bench for finish_req_gen with the watchdog enabled at 100 cycles.
module tb_finish_req_gen;

    localparam logic [31:0] TOHOST = 32'h4000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        drain_busy;
    logic [8:0]  finish_arg;
    logic        halted;
    logic        timed_out;

    int n_assert = 0;
    int n_fail   = 0;

    finish_req_gen #(
        .TOHOST_ADDR    (TOHOST),
        .DRAIN_QUIET    (16),
        .WATCHDOG_CYCLES(100)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_st_valid  (st_valid),
        .o_st_ready  (st_ready),
        .i_st_addr   (st_addr),
        .i_st_data   (st_data),
        .i_st_byte_en(st_be),
        .i_drain_busy(drain_busy),
        .o_finish_arg(finish_arg),
        .o_halted    (halted),
        .o_timed_out (timed_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reset asserted mid-cycle, checked while low, released #1 after an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0; drain_busy = 1'b0;
        #1;
        check("rst_finish_arg", 32'(finish_arg), 32'h000);
        check("rst_st_ready",   32'(st_ready),   32'h1);
        check("rst_halted",     32'(halted),     32'h0);
        check("rst_timed_out",  32'(timed_out),  32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present a store for exactly one edge; returns #1 after that edge.
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
        @(posedge clk);
        #1 st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    endtask

    // Edges until the finish strobe is seen (-1 if never within the bound).
    task automatic wait_finish(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (finish_arg[8]) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (finish_arg[8]) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        bit seen;

        // 1: pass exit
        do_reset();
        store(TOHOST, 32'h1, 4'hF);
        check("t1_drain_ready", 32'(st_ready), 32'h0);
        wait_finish(n);
        check("t1_latency", 32'(n), 32'd17);
        check("t1_arg", 32'(finish_arg), 32'h100);
        check("t1_fire_ready", 32'(st_ready), 32'h0);
        @(posedge clk); #1;
        check("t1_post_arg", 32'(finish_arg), 32'h000);
        check("t1_halted", 32'(halted), 32'h1);
        check("t1_halt_ready", 32'(st_ready), 32'h1);
        check("t1_timed_out", 32'(timed_out), 32'h0);

        // 2: fail code, upper data bits ignored
        do_reset();
        store(TOHOST, 32'hFFFF_FE55, 4'hF);
        wait_finish(n);
        check("t2_latency", 32'(n), 32'd17);
        check("t2_arg", 32'(finish_arg), 32'h12A);
        @(posedge clk); #1;
        check("t2_post_arg", 32'(finish_arg), 32'h02A);

        // 3: non-exit stores are acked and dropped
        do_reset();
        store(TOHOST, 32'h54, 4'hF);
        check("t3_tag0_ready", 32'(st_ready), 32'h1);
        store(TOHOST, 32'h1, 4'h1);
        check("t3_be_ready", 32'(st_ready), 32'h1);
        store(TOHOST + 32'd4, 32'h1, 4'hF);
        check("t3_addr_ready", 32'(st_ready), 32'h1);
        count_strobes(20, cnt);
        check("t3_no_strobe", 32'(cnt), 32'd0);
        check("t3_halted", 32'(halted), 32'h0);
        store(TOHOST, 32'h7, 4'h3);
        wait_finish(n);
        check("t3_then_exit_lat", 32'(n), 32'd17);
        check("t3_then_exit_arg", 32'(finish_arg), 32'h103);

        // 4: drain holds finish; 1-cycle quiet glitch must not count
        do_reset();
        store(TOHOST, 32'h1, 4'hF);
        drain_busy = 1'b1;
        seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (finish_arg[8]) seen = 1'b1;
            if (i == 9)  drain_busy = 1'b0;
            if (i == 10) drain_busy = 1'b1;
        end
        drain_busy = 1'b0;
        check("t4_no_early_fire", 32'(seen), 32'h0);
        wait_finish(n);
        check("t4_latency", 32'(n), 32'd17);
        check("t4_arg", 32'(finish_arg), 32'h100);

        // 5a: watchdog expiry with no stores
        do_reset();
        wait_finish(n);
        check("t5_wd_latency", 32'(n), 32'd117);
        check("t5_wd_arg", 32'(finish_arg), 32'h1FF);
        check("t5_wd_timed_out", 32'(timed_out), 32'h1);

        // 5b: store on the expiry cycle wins
        do_reset();
        repeat (99) @(posedge clk);
        #1;
        store(TOHOST, 32'h3, 4'hF);
        wait_finish(n);
        check("t5_race_latency", 32'(n), 32'd17);
        check("t5_race_arg", 32'(finish_arg), 32'h101);
        check("t5_race_timed_out", 32'(timed_out), 32'h0);

        // 6: reset mid-drain discards pending exit
        do_reset();
        store(TOHOST, 32'h5, 4'hF);
        repeat (5) @(posedge clk);
        #1;
        check("t6_mid_drain_ready", 32'(st_ready), 32'h0);
        do_reset();
        store(TOHOST, 32'h1, 4'hF);
        count_strobes(40, cnt);
        check("t6_one_strobe", 32'(cnt), 32'd1);
        check("t6_halted", 32'(halted), 32'h1);
        check("t6_code", 32'(finish_arg), 32'h000);
        check("t6_halt_ready", 32'(st_ready), 32'h1);
        store(TOHOST, 32'h3, 4'hF);
        count_strobes(40, cnt);
        check("t6_no_restrobe", 32'(cnt), 32'd0);
        check("t6_code_frozen", 32'(finish_arg), 32'h000);
        check("t6_still_halted", 32'(halted), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
